// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | fetch_unit: credit-limited instruction fetch with in-order response queue.  |
// | Optional halt-on-ebreak behaviour is enabled by defining FETCH_HALT_EN.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
  parameter int                 width    = 32,
  parameter int                 DEPTH    = 2,
  parameter logic [width-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [width-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [width-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [width-1:0] instr,
  output logic [width-1:0] instr_pc,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [width-1:0] redirect_pc,
  output logic             ending
);

  localparam int C_PW = $clog2(DEPTH);
  localparam int C_CW = $clog2(DEPTH + 1);
  localparam int C_DW = C_CW + 3;

  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_RUN    = 2'd1;
  localparam logic [1:0] C_ST_HALTED = 2'd2;

  localparam logic [C_PW-1:0] C_LAST_PTR = C_PW'(DEPTH - 1);
  localparam logic [C_CW:0]   C_DEPTH    = (C_CW + 1)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] resp_pc_q, resp_pc_d;
  logic [width-1:0] data_q [DEPTH];
  logic [width-1:0] data_d [DEPTH];
  logic [width-1:0] addr_q [DEPTH];
  logic [width-1:0] addr_d [DEPTH];
  logic [C_PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [C_PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [C_CW-1:0]  count_q, count_d;
  logic [C_CW-1:0]  outst_q, outst_d;
  logic [C_DW-1:0]  discard_q, discard_d;

  logic             w_active;
  logic             w_redirect;
  logic             w_pop;
  logic [C_CW:0]    w_used;
  logic [C_DW-1:0]  w_inflight;
  logic             w_req;
  logic             w_req_fire;
  logic             w_rsp;
  logic             w_drop;
  logic             w_push;
  logic             w_halt;
  logic             w_flush;

  function automatic logic [C_PW-1:0] f_next(input logic [C_PW-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + C_PW'(1);
  endfunction

  assign w_active   = (state_q == C_ST_RUN);
  assign w_redirect = redirect && (state_q != C_ST_HALTED);
  assign w_pop      = instr_valid && instr_ready;

  // Credit counts the entry leaving this cycle so a full queue still streams.
  assign w_used     = (C_CW + 1)'(outst_q) + (C_CW + 1)'(count_q) - (C_CW + 1)'(w_pop);
  assign w_inflight = discard_q + C_DW'(outst_q);
  assign w_req      = w_active && (w_used < C_DEPTH) && (w_inflight != '1);
  assign w_req_fire = w_req && imem_ready;

  // A response with nothing in flight is stale (e.g. straddling reset) and is ignored.
  assign w_rsp      = imem_rvalid && (w_inflight != '0);
  assign w_drop     = w_rsp && (discard_q != '0);
  assign w_flush    = w_redirect || w_halt;
  assign w_push     = w_rsp && !w_drop && w_active && !w_flush;

`ifdef FETCH_HALT_EN
  localparam logic [width-1:0] C_EBREAK = width'(32'h0010_0073);
  assign w_halt = w_active && w_pop && !w_redirect && (instr == C_EBREAK);
  assign ending = (state_q == C_ST_HALTED);
`else
  assign w_halt = 1'b0;
  assign ending = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE: state_d = C_ST_RUN;
      C_ST_RUN:  if (w_halt) state_d = C_ST_HALTED;
      default:   state_d = state_q;
    endcase

    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    if (w_redirect) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      outst_d   = '0;
      discard_d = w_inflight + C_DW'(w_req_fire) - C_DW'(w_rsp);
    end else begin
      if (w_req_fire) pc_d = pc_q + width'(1);
      outst_d = outst_q + C_CW'(w_req_fire);
      if (w_drop) begin
        discard_d = discard_q - C_DW'(1);
      end else if (w_rsp) begin
        outst_d   = outst_d - C_CW'(1);
        resp_pc_d = resp_pc_q + width'(1);
      end
    end

    data_d   = data_q;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (w_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        data_d[wr_ptr_q] = imem_rdata;
        addr_d[wr_ptr_q] = resp_pc_q;
        wr_ptr_d         = f_next(wr_ptr_q);
      end
      if (w_pop) rd_ptr_d = f_next(rd_ptr_q);
      count_d = count_q + C_CW'(w_push) - C_CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= C_ST_IDLE;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end

  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = addr_q[rd_ptr_q];
  assign imem_req    = w_req;
  assign imem_addr   = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_unit: randomized scoreboard bench for fetch_unit (FETCH_HALT_EN    |
// | selects the halt expectations). Revision: 1.0                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;
  localparam int          W      = 32;
  localparam int          D      = 2;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req, imem_ready, imem_rvalid;
  logic [W-1:0]  imem_addr, imem_rdata;
  logic          instr_valid, instr_ready, redirect, ending;
  logic [W-1:0]  instr, instr_pc, redirect_pc;

  logic          w_req, w_rvalid, w_ivalid, w_end, w_pend;
  logic          w_ready = 1'b1, w_iready = 1'b1, w_redir = 1'b0;
  logic [W-1:0]  w_addr, w_rdata, w_instr, w_ipc, w_paddr;
  logic [W-1:0]  w_rpc = '0;
  logic [31:0]   w_log [$];
  logic [31:0]   w_dlog [$];

  always #5 clk = ~clk;

  fetch_unit #(.width(W), .DEPTH(D), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .ending(ending));

  fetch_unit #(.width(W), .DEPTH(D), .RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instr_valid(w_ivalid), .instr(w_instr), .instr_pc(w_ipc),
    .instr_ready(w_iready), .redirect(w_redir), .redirect_pc(w_rpc),
    .ending(w_end));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int acc_cnt = 0;
  int last_due = 0;
  int lat_min = 1, lat_max = 1, ready_pct = 100, iready_mode = 0;
  int halt_mode = 0;
  int halt_pop_cyc = -100;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_pc = '0;
  logic        stale = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] pa [$];
  int          pd [$];
  logic [31:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Program image: a scrambled function of the address, ebreak at 5 in halt mode.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_mode != 0 && a == 32'd5) return EBREAK;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0001;
  endfunction

  // Expected program-order stream: consecutive word addresses from a start point.
  task automatic refill(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i));
  endtask

  task automatic tick();
    int due;
    @(posedge clk);
    #1;
    cyc++;
    redirect    = rd_pend;
    redirect_pc = rd_pc;
    if (rd_pend) refill(rd_pc, 1024);
    rd_pend = 1'b0;
    if (stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      stale       = 1'b0;
    end else if (pd.size() != 0 && pd[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pa[0]);
      void'(pa.pop_front());
      void'(pd.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_ready = ($urandom_range(99) < ready_pct);
    case (iready_mode)
      0:       instr_ready = 1'b1;
      1:       instr_ready = 1'($urandom_range(1));
      default: instr_ready = 1'b0;
    endcase
    @(negedge clk);
    if (imem_req && imem_ready) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pa.push_back(imem_addr);
      pd.push_back(due);
      acc_cnt++;
    end
    #1;
  endtask

  task automatic do_reset(input int exp_len);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    pa.delete();
    pd.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_ending", ending, 0);
    reset    = 1'b0;
    last_due = cyc;
    pops     = 0;
    acc_cnt  = 0;
    refill(32'h0, exp_len);
  endtask

  // Scoreboard monitor: every pop is matched against the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_pop: got pc %0h, wanted no instruction", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_pc", instr_pc, mon_e);
          check("pop_instr", instr, mem_word(mon_e));
          if (halt_mode != 0 && mon_e == 32'd5) halt_pop_cyc = cyc;
          pops++;
        end
      end
    end
  end

  // Latency-1 memory and pop logger for the wrap-around instance.
  initial begin
    w_rvalid = 1'b0;
    w_rdata  = '0;
    forever begin
      @(negedge clk);
      w_pend  = !reset && w_req;
      w_paddr = w_addr;
      if (!reset && w_ivalid) begin
        w_log.push_back(w_ipc);
        w_dlog.push_back(w_instr);
      end
      @(posedge clk);
      #1;
      w_rvalid = w_pend;
      w_rdata  = w_paddr ^ 32'h0F0F_0F0F;
    end
  end

  initial begin
    int max_infl, any_end, viol, first_end;
    logic [31:0] hold_pc, hold_instr;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Steady streaming after reset, latency 1.
    do_reset(1024);
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 0);
    check("valid_t1", instr_valid, 0);
    tick();
    check("valid_t2", instr_valid, 0);
    tick();
    check("valid_t3", instr_valid, 1);
    check("first_pc", instr_pc, 0);
    for (int i = 0; i < 9; i++) tick();
    check("stream_rate", pops, 10);
    check("wrap_log_len", w_log.size() >= 2, 1);
    if (w_log.size() >= 2) begin
      check("wrap_pc0", w_log[0], 32'hFFFF_FFFF);
      check("wrap_pc1", w_log[1], 32'h0);
      check("wrap_instr1", w_dlog[1], 32'h0F0F_0F0F);
    end

    // Back-pressure: random traffic, then a 10-cycle stall.
    do_reset(1024);
    lat_min = 1; lat_max = 3; ready_pct = 70; iready_mode = 1;
    for (int i = 0; i < 40; i++) tick();
    ready_pct = 100; iready_mode = 2; max_infl = 0;
    hold_pc = '0; hold_instr = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc_cnt - pops > max_infl) max_infl = acc_cnt - pops;
      if (i == 4) begin
        check("hold_valid", instr_valid, 1);
        hold_pc = instr_pc;
        hold_instr = instr;
      end
    end
    check("credit_limit", max_infl <= D, 1);
    check("hold_pc", instr_pc, hold_pc);
    check("hold_instr", instr, hold_instr);
    iready_mode = 0;
    for (int i = 0; i < 20; i++) tick();
    iready_mode = 2;
    for (int i = 0; i < 8; i++) tick();
    check("full_before_reset", instr_valid, 1);

    // Reset with a full queue, stale response, then redirect with 2 in flight.
    lat_min = 3; lat_max = 3; ready_pct = 100;
    do_reset(1024);
    iready_mode = 0;
    stale = 1'b1;
    tick();
    tick();
    check("stale_dropped", instr_valid, 0);
    check("in_flight_2", pa.size(), 2);
    rd_pend = 1'b1; rd_pc = 32'h40;
    tick();
    tick();
    check("flush_valid", instr_valid, 0);
    for (int i = 0; i < 8; i++) tick();
    check("discard_zero", dut.discard_q, 0);
    check("redirect_progress", pops >= 3, 1);

    // Random traffic with random redirects.
    lat_min = 1; lat_max = 4; ready_pct = 75; iready_mode = 1;
    pops = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 4) begin
        rd_pend = 1'b1;
        rd_pc = $urandom;
      end
      tick();
    end
    check("random_progress", pops > 100, 1);

    // ebreak at word 5.
    halt_mode = 1;
    lat_min = 1; lat_max = 2; ready_pct = 100; iready_mode = 0;
`ifdef FETCH_HALT_EN
    do_reset(6);
`else
    do_reset(1024);
`endif
    any_end = 0; viol = 0; first_end = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ending) begin
        any_end = 1;
        if (first_end < 0) first_end = cyc;
        if (imem_req) viol++;
      end
    end
`ifdef FETCH_HALT_EN
    check("halt_ending", ending, 1);
    check("halt_timing", first_end, halt_pop_cyc + 1);
    check("halt_no_req", viol, 0);
    check("halt_pops", pops, 6);
    check("halt_valid", instr_valid, 0);
`else
    check("no_halt_ending", any_end, 0);
    check("no_halt_progress", pops > 6, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
